// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - loader state encoding and image framing constants
package loader_pkg;

    typedef enum logic [2:0] {
        HDR,
        WORD,
        STORE,
        GAP,
        DONE,
        ERR
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_STRIDE    = 4;

endpackage

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - RAM port operation and access-size encodings shared by RAM clients
package ram_pkg;

    typedef enum logic [1:0] {
        RAM_NOP,
        RAM_LOAD,
        RAM_STORE
    } ram_op_t;

    typedef enum logic [1:0] {
        RAM_BYTE,
        RAM_HALF,
        RAM_WORD,
        RAM_LONG
    } ram_size_t;

endpackage

// File: rtl/byte_assembler.sv
// rtl/byte_assembler.sv - big-endian byte-to-word shift register with byte counter
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clr        : drop any partial word (wins over en)
//   en         : shift byte_in in on this edge
//   byte_in    : byte to shift in, MSB-first order
//   word_out   : registered shift-register contents
//   full       : the byte accepted this cycle completes a word (combinational)
module byte_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        full
);

    logic [31:0] word_q, word_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clr) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (en) begin
            word_d = {word_q[23:0], byte_in};
            // Counter wraps to zero after the last byte, so the next word starts clean.
            cnt_d  = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_out = word_q;
    // Asserted alongside the final byte so the consumer can act on the same edge.
    assign full     = en && !clr && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/rx_loader.sv
// rtl/rx_loader.sv - serial program loader: rx bytes to consecutive RAM_LONG stores
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   rx_empty       : rx pipe has no byte
//   rx_data        : head byte of the rx pipe (first-word-fall-through)
//   rx_error       : rx framing/overrun error, aborts the load
//   rx_pop         : consume head byte on this edge (combinational)
//   ram_op         : RAM_STORE for one cycle per word, RAM_NOP otherwise
//   ram_size       : always RAM_LONG
//   ram_addr       : store address, starts at BASE_ADDR, steps by 4
//   ram_data_in    : {32'h0, word} while storing, zero otherwise
//   words_loaded   : number of completed stores
//   done           : whole image stored (sticky until rst)
//   error          : load aborted (sticky until rst)
module rx_loader
    import ram_pkg::*;
    import loader_pkg::*;
#(
    parameter int          ADDRW     = 17,
    parameter int unsigned BASE_ADDR = 0,
    parameter int          MAX_WORDS = 2 ** (ADDRW - 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_empty,
    input  logic [7:0]       rx_data,
    input  logic             rx_error,
    output logic             rx_pop,
    output ram_op_t          ram_op,
    output ram_size_t        ram_size,
    output logic [ADDRW-1:0] ram_addr,
    output logic [63:0]      ram_data_in,
    output logic [ADDRW-2:0] words_loaded,
    output logic             done,
    output logic             error
);

    localparam logic [ADDRW-1:0] BASE   = ADDRW'(BASE_ADDR);
    localparam logic [ADDRW-1:0] STRIDE = ADDRW'(WORD_STRIDE);
    localparam logic [31:0]      MAX_N  = 32'(MAX_WORDS);

    loader_state_t    state_q, state_d;
    logic [31:0]      count_q, count_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic [ADDRW-2:0] wl_q, wl_d;

    logic [31:0] asm_word;
    logic        asm_full;
    logic [31:0] hdr_value;
    logic        loading;

    assign loading = (state_q == HDR) || (state_q == WORD) ||
                     (state_q == STORE) || (state_q == GAP);

    assign rx_pop = !rst && ((state_q == HDR) || (state_q == WORD)) && !rx_empty;

    byte_assembler u_asm (
        .clk      (clk),
        .rst      (rst),
        .clr      (rx_error),
        .en       (rx_pop),
        .byte_in  (rx_data),
        .word_out (asm_word),
        .full     (asm_full)
    );

    // The count is decided on the edge that accepts its last byte, so the
    // final byte is merged in here rather than waiting for the register.
    assign hdr_value = {asm_word[23:0], rx_data};

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        wl_d    = wl_q;
        unique case (state_q)
            HDR: begin
                if (asm_full) begin
                    count_d = hdr_value;
                    if (hdr_value == 32'd0) begin
                        state_d = DONE;
                    end else if (hdr_value > MAX_N) begin
                        state_d = ERR;
                    end else begin
                        state_d = WORD;
                    end
                end
            end
            WORD: begin
                if (asm_full) begin
                    state_d = STORE;
                end
            end
            STORE: begin
                state_d = GAP;
            end
            GAP: begin
                addr_d = addr_q + STRIDE;
                wl_d   = wl_q + 1'b1;
                if (32'(wl_q) + 32'd1 == count_q) begin
                    state_d = DONE;
                end else begin
                    state_d = WORD;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = ERR;
            end
        endcase
        if (rx_error && loading) begin
            state_d = ERR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HDR;
            count_q <= '0;
            addr_q  <= BASE;
            wl_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            wl_q    <= wl_d;
        end
    end

    // A store still showing while rst is asserted is suppressed so it never reaches RAM.
    assign ram_op       = (state_q == STORE && !rst) ? RAM_STORE : RAM_NOP;
    assign ram_size     = RAM_LONG;
    assign ram_addr     = addr_q;
    assign ram_data_in  = (state_q == STORE) ? {32'h0, asm_word} : 64'h0;
    assign words_loaded = wl_q;
    assign done         = (state_q == DONE);
    assign error        = (state_q == ERR);

endmodule
